// File: rtl/cam_pkg.sv
// Shared types and helpers for the pipelined CAM: default geometry, entry
// layout and the lowest-index priority encoder used for search and free-slot lookup.
package cam_pkg;

  localparam int unsigned WORD_SIZE_DEF = 32;
  localparam int unsigned NUM_ELEMS_DEF = 32;

  // Encoder capacity; NUM_ELEMS must not exceed MAX_ELEMS.
  localparam int unsigned MAX_ELEMS    = 256;
  localparam int unsigned MAX_IDX_BITS = $clog2(MAX_ELEMS);

  typedef struct packed {
    logic                     valid;
    logic [WORD_SIZE_DEF-1:0] data;
  } entry_t;

  typedef struct packed {
    logic                    found;
    logic [MAX_IDX_BITS-1:0] index;
    logic                    multi;
  } prio_t;

  // Lowest set bit wins; multi flags a second set bit anywhere above it.
  function automatic prio_t prio_encode(input logic [MAX_ELEMS-1:0] vec);
    prio_t res;
    res = '0;
    for (int unsigned i = 0; i < MAX_ELEMS; i++) begin
      if (vec[i]) begin
        if (res.found) begin
          res.multi = 1'b1;
        end else begin
          res.found = 1'b1;
          res.index = MAX_IDX_BITS'(i);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/cam_entry.sv
// One CAM slot: valid/data storage with write-over-invalidate priority and
// ternary (masked) match against the broadcast search key.
module cam_entry
  import cam_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write_en_i,
  input  logic                 invalidate_en_i,
  input  logic [WORD_SIZE-1:0] write_data_i,
  input  logic [WORD_SIZE-1:0] search_data_i,
  input  logic [WORD_SIZE-1:0] search_mask_i,
  output logic                 valid_o,
  output logic [WORD_SIZE-1:0] data_o,
  output logic                 hit_o
);

  typedef struct packed {
    logic                 valid;
    logic [WORD_SIZE-1:0] data;
  } slot_t;

  slot_t slot_q;

  // Data is deliberately left out of reset; only the valid bit is cleared.
  always_ff @(posedge clk) begin
    if (write_en_i) slot_q.data <= write_data_i;
    if (rst) begin
      slot_q.valid <= 1'b0;
    end else if (write_en_i) begin
      slot_q.valid <= 1'b1;
    end else if (invalidate_en_i) begin
      slot_q.valid <= 1'b0;
    end
  end

  always_comb begin
    valid_o = slot_q.valid;
    data_o  = slot_q.data;
    hit_o   = slot_q.valid &&
              (((slot_q.data ^ search_data_i) & search_mask_i) == '0);
  end

endmodule

// File: rtl/cam_pipe.sv
// Parametrised ternary CAM with registered read/search results, multi-hit
// detection, an incremental occupancy counter and lowest-free-slot reporting.
module cam_pipe
  import cam_pkg::*;
#(
  parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
  parameter int unsigned NUM_ELEMS = NUM_ELEMS_DEF,
  localparam int unsigned IDX_BITS = $clog2(NUM_ELEMS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 read_i,
  input  logic [IDX_BITS-1:0]  read_index_i,
  input  logic                 write_i,
  input  logic [IDX_BITS-1:0]  write_index_i,
  input  logic [WORD_SIZE-1:0] write_data_i,
  input  logic                 invalidate_i,
  input  logic [IDX_BITS-1:0]  invalidate_index_i,
  input  logic                 search_i,
  input  logic [WORD_SIZE-1:0] search_data_i,
  input  logic [WORD_SIZE-1:0] search_mask_i,
  output logic                 read_valid_o,
  output logic [WORD_SIZE-1:0] read_value_o,
  output logic                 search_valid_o,
  output logic [IDX_BITS-1:0]  search_index_o,
  output logic                 search_multi_o,
  output logic [IDX_BITS:0]    occupancy_o,
  output logic                 full_o,
  output logic [IDX_BITS-1:0]  free_index_o
);

  localparam int unsigned OCC_W = IDX_BITS + 1;

  logic [NUM_ELEMS-1:0] write_dec;
  logic [NUM_ELEMS-1:0] inv_dec;
  logic [NUM_ELEMS-1:0] valid_vec;
  logic [NUM_ELEMS-1:0] hit_vec;
  logic [WORD_SIZE-1:0] data_arr [NUM_ELEMS];

  logic  occ_inc;
  logic  occ_dec;
  prio_t srch_p;
  prio_t free_p;
  logic  unused_prio;

  // One-hot enables for the addressed slot.
  always_comb begin
    write_dec = '0;
    inv_dec   = '0;
    write_dec[write_index_i]    = write_i;
    inv_dec[invalidate_index_i] = invalidate_i;
  end

  for (genvar k = 0; k < NUM_ELEMS; k++) begin : g_entry
    cam_entry #(
      .WORD_SIZE(WORD_SIZE)
    ) u_entry (
      .clk             (clk),
      .rst             (rst),
      .write_en_i      (write_dec[k]),
      .invalidate_en_i (inv_dec[k]),
      .write_data_i    (write_data_i),
      .search_data_i   (search_data_i),
      .search_mask_i   (search_mask_i),
      .valid_o         (valid_vec[k]),
      .data_o          (data_arr[k]),
      .hit_o           (hit_vec[k])
    );
  end

  // Count only real valid-bit transitions; a same-index write cancels the invalidate.
  always_comb begin
    occ_inc = write_i && !valid_vec[write_index_i];
    occ_dec = invalidate_i && valid_vec[invalidate_index_i] &&
              !(write_i && (write_index_i == invalidate_index_i));
  end

  always_comb begin
    srch_p = prio_encode(MAX_ELEMS'(hit_vec));
    free_p = prio_encode(MAX_ELEMS'(~valid_vec));
  end

  // Encoder index bits above IDX_BITS are always zero for this geometry.
  assign unused_prio = ^{srch_p, free_p};

  always_comb begin
    free_index_o = free_p.found ? IDX_BITS'(free_p.index) : '0;
    full_o       = (occupancy_o == OCC_W'(NUM_ELEMS));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy_o    <= '0;
      read_valid_o   <= 1'b0;
      read_value_o   <= '0;
      search_valid_o <= 1'b0;
      search_index_o <= '0;
      search_multi_o <= 1'b0;
    end else begin
      occupancy_o    <= occupancy_o + OCC_W'(occ_inc) - OCC_W'(occ_dec);
      read_valid_o   <= read_i && valid_vec[read_index_i];
      read_value_o   <= read_i ? data_arr[read_index_i] : '0;
      search_valid_o <= search_i && srch_p.found;
      search_index_o <= (search_i && srch_p.found) ? IDX_BITS'(srch_p.index) : '0;
      search_multi_o <= search_i && srch_p.multi;
    end
  end

endmodule

// File: tb/tb_cam_pipe.sv
// Bench for cam_pipe: directed scenarios followed by random traffic, all
// checked against an array-based table model with popcount occupancy.
module tb_cam_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned N  = 32;
  localparam int unsigned IB = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          read_i = 1'b0;
  logic [IB-1:0] read_index_i = '0;
  logic          write_i = 1'b0;
  logic [IB-1:0] write_index_i = '0;
  logic [W-1:0]  write_data_i = '0;
  logic          invalidate_i = 1'b0;
  logic [IB-1:0] invalidate_index_i = '0;
  logic          search_i = 1'b0;
  logic [W-1:0]  search_data_i = '0;
  logic [W-1:0]  search_mask_i = '0;
  logic          read_valid_o;
  logic [W-1:0]  read_value_o;
  logic          search_valid_o;
  logic [IB-1:0] search_index_o;
  logic          search_multi_o;
  logic [IB:0]   occupancy_o;
  logic          full_o;
  logic [IB-1:0] free_index_o;

  always #5 clk = ~clk;

  cam_pipe #(.WORD_SIZE(W), .NUM_ELEMS(N)) dut (
    .clk                (clk),
    .rst                (rst),
    .read_i             (read_i),
    .read_index_i       (read_index_i),
    .write_i            (write_i),
    .write_index_i      (write_index_i),
    .write_data_i       (write_data_i),
    .invalidate_i       (invalidate_i),
    .invalidate_index_i (invalidate_index_i),
    .search_i           (search_i),
    .search_data_i      (search_data_i),
    .search_mask_i      (search_mask_i),
    .read_valid_o       (read_valid_o),
    .read_value_o       (read_value_o),
    .search_valid_o     (search_valid_o),
    .search_index_o     (search_index_o),
    .search_multi_o     (search_multi_o),
    .occupancy_o        (occupancy_o),
    .full_o             (full_o),
    .free_index_o       (free_index_o)
  );

  bit           m_valid [N];
  logic [W-1:0] m_data  [N];
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive requests, predict from pre-edge table, update table, check.
  task automatic cycle(input bit r, input bit rd, input int ri,
                       input bit wr, input int wi, input logic [W-1:0] wd,
                       input bit inv, input int ii,
                       input bit sr, input logic [W-1:0] sd, input logic [W-1:0] sm);
    bit           e_rv, e_sv, e_sm, chk_rval;
    logic [W-1:0] e_rval;
    int           e_si, hits, cnt, e_free;
    rst = r;
    read_i = rd;        read_index_i = IB'(ri);
    write_i = wr;       write_index_i = IB'(wi);   write_data_i = wd;
    invalidate_i = inv; invalidate_index_i = IB'(ii);
    search_i = sr;      search_data_i = sd;        search_mask_i = sm;

    e_rv     = rd && m_valid[ri];
    e_rval   = e_rv ? m_data[ri] : '0;
    chk_rval = !rd || e_rv;
    hits = 0;
    e_si = 0;
    for (int k = 0; k < N; k++) begin
      if (m_valid[k] && (((m_data[k] ^ sd) & sm) == '0)) begin
        if (hits == 0) e_si = k;
        hits++;
      end
    end
    e_sv = sr && (hits > 0);
    e_sm = sr && (hits > 1);
    if (!e_sv) e_si = 0;
    if (r) begin
      e_rv = 1'b0; e_rval = '0; chk_rval = 1'b1;
      e_sv = 1'b0; e_sm = 1'b0; e_si = 0;
      for (int k = 0; k < N; k++) m_valid[k] = 1'b0;
    end else begin
      if (inv) m_valid[ii] = 1'b0;
      if (wr) begin
        m_valid[wi] = 1'b1;
        m_data[wi]  = wd;
      end
    end

    @(posedge clk);
    #1;
    cnt = 0;
    e_free = -1;
    for (int k = 0; k < N; k++) begin
      if (m_valid[k]) cnt++;
      else if (e_free < 0) e_free = k;
    end
    if (e_free < 0) e_free = 0;
    chk("read_valid", 64'(read_valid_o), 64'(e_rv));
    if (chk_rval) chk("read_value", 64'(read_value_o), 64'(e_rval));
    chk("search_valid", 64'(search_valid_o), 64'(e_sv));
    chk("search_index", 64'(search_index_o), 64'(e_si));
    chk("search_multi", 64'(search_multi_o), 64'(e_sm));
    chk("occupancy", 64'(occupancy_o), 64'(cnt));
    chk("full", 64'(full_o), 64'(cnt == N));
    chk("free_index", 64'(free_index_o), 64'(e_free));
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] key, msk;
    int           occ_before;
    for (int k = 0; k < N; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = '0;
    end
    @(negedge clk);

    // Reset and idle search
    cycle(1, 0, 0, 0, 0, '0, 0, 0, 0, '0, '0);
    cycle(1, 0, 0, 0, 0, '0, 0, 0, 0, '0, '0);
    chk("rst_occ", 64'(occupancy_o), 64'd0);
    chk("rst_free", 64'(free_index_o), 64'd0);
    cycle(0, 0, 0, 0, 0, '0, 0, 0, 1, 32'h0, '1);
    chk("empty_search", 64'(search_valid_o), 64'd0);

    // Read-after-write latency
    cycle(0, 1, 5, 1, 5, 32'hDEADBEEF, 0, 0, 0, '0, '0);
    chk("raw_old_valid", 64'(read_valid_o), 64'd0);
    cycle(0, 1, 5, 0, 0, '0, 0, 0, 0, '0, '0);
    chk("raw_new_value", 64'(read_value_o), 64'hDEADBEEF);

    // Masked priority and multi-hit
    cycle(0, 0, 0, 1, 3, 32'h12340001, 0, 0, 0, '0, '0);
    cycle(0, 0, 0, 1, 9, 32'h12340002, 0, 0, 0, '0, '0);
    cycle(0, 0, 0, 0, 0, '0, 0, 0, 1, 32'h12340000, 32'hFFFF0000);
    chk("prio_index", 64'(search_index_o), 64'd3);
    chk("prio_multi", 64'(search_multi_o), 64'd1);
    cycle(0, 0, 0, 0, 0, '0, 0, 0, 1, 32'h12340000, '1);
    chk("exact_nohit", 64'(search_valid_o), 64'd0);

    // Invalidate and write-wins
    occ_before = int'(occupancy_o);
    cycle(0, 0, 0, 0, 0, '0, 1, 3, 0, '0, '0);
    chk("inv_occ", 64'(occupancy_o), 64'(occ_before - 1));
    cycle(0, 0, 0, 0, 0, '0, 0, 0, 1, 32'h12340000, 32'hFFFF0000);
    chk("inv_index", 64'(search_index_o), 64'd9);
    occ_before = int'(occupancy_o);
    cycle(0, 0, 0, 1, 9, 32'h55AA55AA, 1, 9, 0, '0, '0);
    chk("ww_occ", 64'(occupancy_o), 64'(occ_before));
    cycle(0, 1, 9, 0, 0, '0, 0, 0, 0, '0, '0);
    chk("ww_value", 64'(read_value_o), 64'h55AA55AA);

    // Fill, overwrite, free-slot report
    for (int i = 0; i < N; i++)
      cycle(0, 0, 0, 1, i, 32'h01010101 * W'(i) + 32'hA5, 0, 0, 0, '0, '0);
    chk("fill_occ", 64'(occupancy_o), 64'd32);
    chk("fill_full", 64'(full_o), 64'd1);
    cycle(0, 0, 0, 1, 0, 32'hCAFE0000, 0, 0, 0, '0, '0);
    chk("overwrite_occ", 64'(occupancy_o), 64'd32);
    cycle(0, 0, 0, 0, 0, '0, 1, 17, 0, '0, '0);
    chk("free17", 64'(free_index_o), 64'd17);
    chk("notfull", 64'(full_o), 64'd0);

    // Mid-operation reset
    cycle(0, 0, 0, 0, 0, '0, 0, 0, 1, 32'hCAFE0000, '1);
    chk("pre_rst_hit", 64'(search_valid_o), 64'd1);
    cycle(1, 1, 0, 0, 0, '0, 0, 0, 1, 32'hCAFE0000, '1);
    chk("rst_search", 64'(search_valid_o), 64'd0);
    cycle(0, 1, 0, 0, 0, '0, 0, 0, 0, '0, '0);
    chk("rst_read", 64'(read_valid_o), 64'd0);

    // Random traffic
    for (int t = 0; t < 3000; t++) begin
      key = m_data[$urandom_range(0, N - 1)];
      case ($urandom_range(0, 3))
        0:       msk = '1;
        1:       msk = '0;
        2:       msk = W'($urandom());
        default: msk = W'($urandom()) & W'($urandom());
      endcase
      if ($urandom_range(0, 2) == 0) key = W'($urandom());
      else key = key ^ (W'($urandom()) & ~msk);
      cycle($urandom_range(0, 299) == 0,
            $urandom_range(0, 9) < 7, $urandom_range(0, N - 1),
            $urandom_range(0, 9) < 5, $urandom_range(0, N - 1),
            ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 7)) : W'($urandom()),
            $urandom_range(0, 9) < 3, $urandom_range(0, N - 1),
            $urandom_range(0, 9) < 7, key, msk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
